// File: rtl/z16_instr_encoder.sv
// z16_instr_encoder
// Packs decoded Z16 instruction fields into 16-bit instruction words.
// Accepted words are buffered in a small FIFO and written to consecutive
// instruction-memory addresses through a granted write port.
// Build option: define Z16_ENC_RANGE_CHECK_EN to reject beats whose immediate
// does not fit its field (sets o_err, counts o_rej_cnt). When it is left
// undefined, immediates are truncated to the field width and o_err/o_rej_cnt
// are held at zero.
module z16_instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                ADDR_STEP = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [3:0]        i_rd,
  input  logic [3:0]        i_rs1,
  input  logic [3:0]        i_rs2,
  input  logic [15:0]       i_imm,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  output logic              o_busy,
  output logic              o_err,
  output logic [7:0]        o_rej_cnt
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Pack fields into the Z16 word; only the low immediate byte can land in a field.
  function automatic logic [15:0] f_encode(input logic [3:0] op, input logic [3:0] rd,
                                           input logic [3:0] rs1, input logic [3:0] rs2,
                                           input logic [7:0] imm8);
    logic [15:0] word;
    case (op)
      4'h9:             word = {imm8, rd, op};
      4'hA, 4'hC, 4'hD: word = {imm8[3:0], rs1, rd, op};
      4'hB:             word = {rs2, rs1, imm8[3:0], op};
      default:          word = {rs2, rs1, rd, op};
    endcase
    return word;
  endfunction

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_fits;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_word;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == {CNT_W{1'b0}});
  assign o_ready  = !w_full && !i_clear;
  assign w_accept = i_valid && o_ready;
  assign w_word   = f_encode(i_opcode, i_rd, i_rs1, i_rs2, i_imm[7:0]);
  assign w_push   = w_accept && w_fits;
  // A clear cycle never retires the head word, even if the memory grants it.
  assign w_pop    = !w_empty && i_mem_gnt && !i_clear;

  assign o_mem_wen   = !w_empty;
  assign o_busy      = !w_empty;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = w_empty ? 16'h0000 : r_mem[r_rd_ptr];

`ifdef Z16_ENC_RANGE_CHECK_EN
  // True when the sign-extended immediate fits the field its opcode encodes.
  function automatic logic f_imm_fits(input logic [3:0] op, input logic [15:0] imm);
    logic ok;
    case (op)
      4'h9:                   ok = (imm[15:7] == 9'h000) || (imm[15:7] == 9'h1FF);
      4'hA, 4'hB, 4'hC, 4'hD: ok = (imm[15:3] == 13'h0000) || (imm[15:3] == 13'h1FFF);
      default:                ok = 1'b1;
    endcase
    return ok;
  endfunction

  logic       w_rej;
  logic       r_err;
  logic [7:0] r_rej_cnt;

  assign w_fits    = f_imm_fits(i_opcode, i_imm);
  assign w_rej     = w_accept && !w_fits;
  assign o_err     = r_err;
  assign o_rej_cnt = r_rej_cnt;

  // Sticky reject flag and saturating reject counter; clear wipes both.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err     <= 1'b0;
      r_rej_cnt <= 8'h00;
    end else if (i_clear) begin
      r_err     <= 1'b0;
      r_rej_cnt <= 8'h00;
    end else if (w_rej) begin
      r_err <= 1'b1;
      if (r_rej_cnt != 8'hFF) begin
        r_rej_cnt <= r_rej_cnt + 8'h01;
      end
    end
  end
`else
  logic w_unused_imm;

  assign w_fits       = 1'b1;
  assign w_unused_imm = ^i_imm[15:8];
  assign o_err        = 1'b0;
  assign o_rej_cnt    = 8'h00;
`endif

  // FIFO data storage; occupancy alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Pointers, occupancy and write address; clear takes priority over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_addr   <= BASE_ADDR;
    end else if (i_clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_addr   <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_addr   <= r_addr + STEP;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_z16_instr_encoder.sv
// Scoreboard bench for z16_instr_encoder: a driver applies directed and random
// beats and predicts the written words; a monitor compares every memory write.
module tb_z16_instr_encoder;

  localparam int          DEPTH   = 4;
  localparam logic [15:0] TB_BASE = 16'hFFFA;
  localparam int          STEP    = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_opcode = 4'h0;
  logic [3:0]  i_rd = 4'h0;
  logic [3:0]  i_rs1 = 4'h0;
  logic [3:0]  i_rs2 = 4'h0;
  logic [15:0] i_imm = 16'h0000;
  logic        o_mem_wen;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        i_mem_gnt = 1'b0;
  logic        o_busy;
  logic        o_err;
  logic [7:0]  o_rej_cnt;

  always #5 i_clk = ~i_clk;

  z16_instr_encoder #(
    .DEPTH(DEPTH), .ADDR_W(16), .BASE_ADDR(TB_BASE), .ADDR_STEP(STEP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_valid(i_valid),
    .o_ready(o_ready), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_imm(i_imm), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .o_busy(o_busy),
    .o_err(o_err), .o_rej_cnt(o_rej_cnt)
  );

  int          n_pass = 0;
  int          n_tot = 0;
  logic [31:0] sb[$];
  int          m_cnt = 0;
  logic [15:0] m_addr = TB_BASE;
  logic        m_err = 1'b0;
  int          m_rej = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference encoding from the nibble layout, using plain arithmetic.
  function automatic logic [15:0] m_word(input int op, input int rd, input int rs1,
                                         input int rs2, input int imm);
    int n3, n2, n1;
    int imm8 = imm & 255;
    int imm4 = imm & 15;
    if (op == 9) begin
      n3 = imm8 / 16; n2 = imm8 % 16; n1 = rd;
    end else if (op == 10 || op == 12 || op == 13) begin
      n3 = imm4; n2 = rs1; n1 = rd;
    end else if (op == 11) begin
      n3 = rs2; n2 = rs1; n1 = imm4;
    end else begin
      n3 = rs2; n2 = rs1; n1 = rd;
    end
    return 16'(n3 * 4096 + n2 * 256 + n1 * 16 + op);
  endfunction

  function automatic bit m_ok(input int op, input int simm);
    bit fits;
    if (op == 9) fits = (simm >= -128) && (simm <= 127);
    else if (op >= 10 && op <= 13) fits = (simm >= -8) && (simm <= 7);
    else fits = 1'b1;
`ifdef Z16_ENC_RANGE_CHECK_EN
    return fits;
`else
    return fits | 1'b1;
`endif
  endfunction

  // One cycle: called just after a rising edge, returns just after the next one.
  task automatic drive(input bit v, input int op, input int rd, input int rs1, input int rs2,
                       input logic [15:0] imm, input bit g, input bit c);
    bit rdy;
    int simm;
    chk("busy", {31'd0, o_busy}, {31'd0, m_cnt > 0});
    chk("err", {31'd0, o_err}, {31'd0, m_err});
    chk("rej_cnt", {24'd0, o_rej_cnt}, 32'(m_rej));
    i_valid = v; i_opcode = 4'(op); i_rd = 4'(rd); i_rs1 = 4'(rs1); i_rs2 = 4'(rs2);
    i_imm = imm; i_mem_gnt = g; i_clear = c;
    #1;
    rdy = (m_cnt < DEPTH) && !c;
    chk("ready", {31'd0, o_ready}, {31'd0, rdy});
    simm = int'($signed(imm));
    if (c) begin
      sb.delete(); m_cnt = 0; m_addr = TB_BASE; m_err = 1'b0; m_rej = 0;
    end else begin
      if (g && m_cnt > 0) m_cnt--;
      if (v && rdy) begin
        if (m_ok(op, simm)) begin
          sb.push_back({m_addr, m_word(op, rd, rs1, rs2, simm)});
          m_addr = m_addr + 16'(STEP);
          m_cnt++;
        end else begin
          m_err = 1'b1;
          if (m_rej < 255) m_rej++;
        end
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input bit g);
    drive(1'b0, 0, 0, 0, 0, 16'h0000, g, 1'b0);
  endtask

  // Monitor: every presented write must match the oldest expected word.
  always @(negedge i_clk) begin
    if (i_rst_n && !i_clear && o_mem_wen) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL write: got addr %h data %h expected no write at %0t",
                 o_mem_addr, o_mem_wdata, $time);
      end else begin
        chk("write", {o_mem_addr, o_mem_wdata}, sb[0]);
        if (i_mem_gnt) void'(sb.pop_front());
      end
    end
  end

  function automatic logic [15:0] rand_imm();
    if ($urandom_range(0, 2) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 20)) - 10);
  endfunction

  logic [15:0] a;

  initial begin
    #12 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_wen", {31'd0, o_mem_wen}, 32'd0);
    chk("rst_addr", {16'd0, o_mem_addr}, {16'd0, TB_BASE});
    chk("rst_wdata", {16'd0, o_mem_wdata}, 32'd0);

    // Encoding examples, back to back with grant held high.
    drive(1'b1, 0, 1, 2, 3, 16'h0000, 1'b1, 1'b0);
    chk("add_wdata", {16'd0, o_mem_wdata}, 32'h3210);
    chk("add_addr", {16'd0, o_mem_addr}, {16'd0, TB_BASE});
    drive(1'b1, 9, 4, 7, 7, 16'hFFFE, 1'b1, 1'b0);
    a = TB_BASE + 16'd2;
    chk("op9_wdata", {16'd0, o_mem_wdata}, 32'hFE49);
    chk("op9_addr", {16'd0, o_mem_addr}, {16'd0, a});
    drive(1'b1, 11, 0, 5, 6, 16'h0003, 1'b1, 1'b0);
    chk("opB_wdata", {16'd0, o_mem_wdata}, 32'h653B);
    drive(1'b1, 10, 1, 2, 0, 16'hFFFF, 1'b1, 1'b0);
    a = TB_BASE + 16'd6;
    chk("opA_wdata", {16'd0, o_mem_wdata}, 32'hF21A);
    chk("wrap_addr", {16'd0, o_mem_addr}, {16'd0, a});
    drive(1'b1, 10, 1, 2, 0, 16'h0008, 1'b1, 1'b0);
    a = TB_BASE + 16'd8;
    chk("oor_addr", {16'd0, o_mem_addr}, {16'd0, a});
`ifdef Z16_ENC_RANGE_CHECK_EN
    chk("oor_err", {31'd0, o_err}, 32'd1);
    chk("oor_rej", {24'd0, o_rej_cnt}, 32'd1);
`else
    chk("oor_wdata", {16'd0, o_mem_wdata}, 32'h821A);
`endif
    repeat (2) idle(1'b1);

    // Fill without grant, fifth beat held until space frees.
    for (int k = 0; k < 5; k++) drive(1'b1, 1, k, k + 1, k + 2, 16'h0000, 1'b0, 1'b0);
    chk("full_ready", {31'd0, o_ready}, 32'd0);
    drive(1'b1, 1, 4, 5, 6, 16'h0000, 1'b1, 1'b0);
    drive(1'b1, 1, 4, 5, 6, 16'h0000, 1'b1, 1'b0);
    repeat (6) idle(1'b1);

    // Clear with words buffered and a beat offered in the clear cycle.
    for (int k = 0; k < 3; k++) drive(1'b1, 2, k, 3, 4, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 9, 1, 0, 0, 16'h0100, 1'b0, 1'b0);
    drive(1'b1, 3, 3, 3, 3, 16'h0000, 1'b1, 1'b1);
    chk("clr_busy", {31'd0, o_busy}, 32'd0);
    chk("clr_addr", {16'd0, o_mem_addr}, {16'd0, TB_BASE});
    chk("clr_err", {31'd0, o_err}, 32'd0);
    idle(1'b1);

    // Asynchronous reset with words buffered.
    drive(1'b1, 4, 1, 1, 1, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 5, 2, 2, 2, 16'h0000, 1'b1, 1'b0);
    i_valid = 1'b0; i_mem_gnt = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_wen", {31'd0, o_mem_wen}, 32'd0);
    chk("arst_addr", {16'd0, o_mem_addr}, {16'd0, TB_BASE});
    sb.delete(); m_cnt = 0; m_addr = TB_BASE; m_err = 1'b0; m_rej = 0;
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), rand_imm(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
    end

    // Drain everything still buffered.
    for (int k = 0; k < 20 && sb.size() > 0; k++) idle(1'b1);
    chk("drain", 32'(sb.size()), 32'd0);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
